// File: rtl/cpu_eu_pkg.sv
// Shared encodings for the self-sequencing CPU execution unit:
// opcodes, FSM state codes and flag bit positions.
package cpu_eu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [OPW-1:0] OP_ADD  = 4'h1;
  localparam logic [OPW-1:0] OP_SUB  = 4'h2;
  localparam logic [OPW-1:0] OP_AND  = 4'h3;
  localparam logic [OPW-1:0] OP_OR   = 4'h4;
  localparam logic [OPW-1:0] OP_XOR  = 4'h5;
  localparam logic [OPW-1:0] OP_INC  = 4'h6;
  localparam logic [OPW-1:0] OP_DEC  = 4'h7;
  localparam logic [OPW-1:0] OP_SHL  = 4'h8;
  localparam logic [OPW-1:0] OP_SHR  = 4'h9;
  localparam logic [OPW-1:0] OP_LD   = 4'hA;
  localparam logic [OPW-1:0] OP_ST   = 4'hB;
  localparam logic [OPW-1:0] OP_LDI  = 4'hC;
  localparam logic [OPW-1:0] OP_JMP  = 4'hD;
  localparam logic [OPW-1:0] OP_BZ   = 4'hE;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  localparam int unsigned STW = 3;

  localparam logic [STW-1:0] ST_FETCH  = 3'd0;
  localparam logic [STW-1:0] ST_DECODE = 3'd1;
  localparam logic [STW-1:0] ST_EXEC   = 3'd2;
  localparam logic [STW-1:0] ST_MEMRD  = 3'd3;
  localparam logic [STW-1:0] ST_MEMWR  = 3'd4;
  localparam logic [STW-1:0] ST_HALT   = 3'd5;

  localparam int unsigned NFLAGS = 3;
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 2;

  // Opcodes that write an ALU result and update the flags.
  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/cpu_eu_alu.sv
// Combinational ALU: result and C/N/Z for opcodes 1-9; other opcodes yield zero.
module cpu_eu_alu
  import cpu_eu_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  R,
  input  logic [DW-1:0]  S,
  output logic [DW-1:0]  result,
  output logic           C,
  output logic           N,
  output logic           Z
);

  always_comb begin
    result = '0;
    C      = 1'b0;
    case (op)
      OP_ADD: {C, result} = {1'b0, R} + {1'b0, S};
      OP_SUB: begin
        result = R - S;
        C      = (R < S);
      end
      OP_AND: result = R & S;
      OP_OR:  result = R | S;
      OP_XOR: result = R ^ S;
      OP_INC: {C, result} = {1'b0, R} + (DW+1)'(1);
      OP_DEC: begin
        result = R - DW'(1);
        C      = (R == '0);
      end
      OP_SHL: begin
        result = {R[DW-2:0], 1'b0};
        C      = R[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, R[DW-1:1]};
        C      = R[0];
      end
      default: ;
    endcase
  end

  assign N = result[DW-1];
  assign Z = (result == '0);

endmodule

// File: rtl/cpu_eu_seq.sv
// Self-sequencing execution unit: PC, IR, register file, flags and a
// fetch/decode/execute FSM driving memory through a read-valid handshake.
module cpu_eu_seq
  import cpu_eu_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 8,
  parameter int unsigned NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic          halted,
  output logic          C,
  output logic          N,
  output logic          Z,
  output logic [AW-1:0] pc_dbg
);

  localparam int unsigned RW = $clog2(NREG);

  logic [STW-1:0]    state, state_n;
  logic [AW-1:0]     pc, pc_n;
  logic [DW-1:0]     ir, ir_n;
  logic [DW-1:0]     regs [NREG];
  logic [NFLAGS-1:0] flags, flags_n;

  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic [AW-1:0]     addr_n;
  logic [DW-1:0]     wdata_n;
  logic              re_n, we_n, halted_n;

  logic [OPW-1:0]    op;
  logic [RW-1:0]     fw, fr, fs;
  logic [DW-1:0]     rval, sval;
  logic [AW-1:0]     raddr;
  logic              accept;

  logic [DW-1:0]     alu_res;
  logic              alu_c, alu_n, alu_z;

  assign op     = ir[DW-1:DW-4];
  assign fw     = ir[3*RW-1:2*RW];
  assign fr     = ir[2*RW-1:RW];
  assign fs     = ir[RW-1:0];
  assign rval   = regs[fr];
  assign sval   = regs[fs];
  assign raddr  = rval[AW-1:0];
  // Read data only counts while a request is actually outstanding.
  assign accept = mem_re & mem_rvalid;

  generate
    if (DW > 4 + 3*RW) begin : g_spare
      logic unused_ir;
      assign unused_ir = ^ir[DW-5:3*RW];
    end
  endgenerate

  cpu_eu_alu #(.DW(DW)) u_alu (
    .op     (op),
    .R      (rval),
    .S      (sval),
    .result (alu_res),
    .C      (alu_c),
    .N      (alu_n),
    .Z      (alu_z)
  );

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    flags_n  = flags;
    wr_en    = 1'b0;
    wr_data  = alu_res;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;

    case (state)
      ST_FETCH: begin
        if (accept) begin
          ir_n    = mem_rdata;
          pc_n    = pc + AW'(1);
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LD, OP_LDI: state_n = ST_MEMRD;
          OP_ST:         state_n = ST_MEMWR;
          OP_HALT:       state_n = ST_HALT;
          default:       state_n = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        state_n = ST_FETCH;
        if (is_alu_op(op)) begin
          wr_en           = 1'b1;
          flags_n[FLAG_C] = alu_c;
          flags_n[FLAG_N] = alu_n;
          flags_n[FLAG_Z] = alu_z;
        end else if ((op == OP_JMP) || ((op == OP_BZ) && flags[FLAG_Z])) begin
          pc_n = raddr;
        end
      end
      ST_MEMRD: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          if (op == OP_LDI) pc_n = pc + AW'(1);
          state_n = ST_FETCH;
        end
      end
      ST_MEMWR: state_n = ST_FETCH;
      ST_HALT:  state_n = ST_HALT;
      default:  state_n = ST_FETCH;
    endcase

    // Bus outputs follow the state being entered so they are valid from its first cycle.
    re_n     = (state_n == ST_FETCH) || (state_n == ST_MEMRD);
    we_n     = (state_n == ST_MEMWR);
    halted_n = (state_n == ST_HALT);

    case (state_n)
      ST_FETCH: addr_n = pc_n;
      ST_MEMRD: addr_n = (op == OP_LDI) ? pc_n : raddr;
      ST_MEMWR: begin
        addr_n  = raddr;
        wdata_n = sval;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      flags     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      flags     <= flags_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_re    <= re_n;
      mem_we    <= we_n;
      halted    <= halted_n;
      if (wr_en) regs[fw] <= wr_data;
    end
  end

  assign C      = flags[FLAG_C];
  assign N      = flags[FLAG_N];
  assign Z      = flags[FLAG_Z];
  assign pc_dbg = pc;

endmodule

// File: tb/tb_cpu_eu_seq.sv
// Directed bench for cpu_eu_seq: a behavioural memory with programmable read
// latency, and a scoreboard of expected stores checked as the DUT writes.
module tb_cpu_eu_seq;

  logic        clk;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic        halted;
  logic        C, N, Z;
  logic [7:0]  pc_dbg;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] mem [256];
  wr_t         sb [$];
  int          waits;
  int          age;
  logic        spurious;
  logic [7:0]  ld_ptr;
  logic        prev_pend;
  logic [7:0]  pend_addr;
  logic        prev_we;
  int          n_checks;
  int          n_fails;

  cpu_eu_seq #(.DW(16), .AW(8), .NREG(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .halted     (halted),
    .C          (C),
    .N          (N),
    .Z          (Z),
    .pc_dbg     (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data is valid once a request has been outstanding for 'waits' cycles.
  assign mem_rdata  = mem[mem_addr];
  assign mem_rvalid = (mem_re && (age >= waits)) || spurious;

  always @(posedge clk or posedge reset) begin
    if (reset)                     age <= 0;
    else if (mem_re && mem_rvalid) age <= 0;
    else if (mem_re)               age <= age + 1;
    else                           age <= 0;
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] w,
                                      input logic [2:0] r, input logic [2:0] s);
    return {op, 3'b000, w, r, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [15:0] w);
    mem[ld_ptr] = w;
    ld_ptr      = ld_ptr + 8'd1;
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one cycle and run the bus monitor at the falling edge.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (prev_pend) check("req_hold", {mem_re, mem_addr}, {1'b1, pend_addr});
    prev_pend = mem_re && !mem_rvalid;
    pend_addr = mem_addr;
    if (mem_re) check("re_we_excl", mem_we, 1'b0);
    if (mem_we) begin
      check("we_single", prev_we, 1'b0);
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
      mem[mem_addr] = mem_wdata;
    end
    prev_we = mem_we;
  endtask

  task automatic begin_prog();
    reset     = 1'b1;
    prev_pend = 1'b0;
    prev_we   = 1'b0;
    spurious  = 1'b0;
    waits     = 0;
    sb.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    ld_ptr = 8'h00;
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 600 && !halted; i++) step();
    check(tag, halted, 1'b1);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic prog_a();
    begin_prog();
    emit(enc(4'hC, 3'd1, 3'd0, 3'd0)); emit(16'hFFFF);
    emit(enc(4'hC, 3'd2, 3'd0, 3'd0)); emit(16'h0001);
    emit(enc(4'h1, 3'd3, 3'd1, 3'd2));
    emit(enc(4'hC, 3'd5, 3'd0, 3'd0)); emit(16'h0040);
    emit(enc(4'hB, 3'd0, 3'd5, 3'd3));
    expect_wr(8'h40, 16'h0000);
  endtask

  initial begin
    bit seen;
    n_checks = 0;
    n_fails  = 0;

    // Reset state and first fetch with zero-wait memory.
    begin_prog();
    emit(enc(4'h1, 3'd3, 3'd1, 3'd2));
    check("rst_outs", {mem_re, mem_we, halted, C, N, Z}, 6'b0);
    check("rst_addr", {mem_addr, pc_dbg}, 16'h0000);
    reset = 1'b0;
    step();
    check("fetch1_req", {mem_re, mem_addr, pc_dbg}, {1'b1, 8'h00, 8'h00});
    step();
    check("fetch1_pc", {mem_re, pc_dbg}, {1'b0, 8'h01});
    run_to_halt("t1_halt");
    check("t1_flags", {C, N, Z}, 3'b001);
    check("t1_pc", pc_dbg, 8'h02);

    // ADD with carry-out to zero, zero-wait then three wait states per read.
    prog_a();
    reset = 1'b0;
    run_to_halt("add_halt");
    check("add_flags", {C, N, Z}, 3'b101);
    prog_a();
    waits = 3;
    reset = 1'b0;
    run_to_halt("add_wait_halt");
    check("add_wait_flags", {C, N, Z}, 3'b101);
    check("add_wait_pc", pc_dbg, 8'h09);

    // SUB with borrow.
    begin_prog();
    emit(enc(4'hC, 3'd1, 3'd0, 3'd0)); emit(16'hFFFF);
    emit(enc(4'hC, 3'd2, 3'd0, 3'd0)); emit(16'h0001);
    emit(enc(4'h2, 3'd4, 3'd2, 3'd1));
    emit(enc(4'hC, 3'd5, 3'd0, 3'd0)); emit(16'h0041);
    emit(enc(4'hB, 3'd0, 3'd5, 3'd4));
    expect_wr(8'h41, 16'h0002);
    reset = 1'b0;
    run_to_halt("sub_halt");
    check("sub_flags", {C, N, Z}, 3'b100);

    // Store then load back; rvalid held high everywhere to show it is ignored.
    begin_prog();
    spurious = 1'b1;
    emit(enc(4'hC, 3'd5, 3'd0, 3'd0)); emit(16'h0040);
    emit(enc(4'hC, 3'd6, 3'd0, 3'd0)); emit(16'hBEEF);
    emit(enc(4'h8, 3'd1, 3'd6, 3'd0));
    emit(enc(4'hB, 3'd0, 3'd5, 3'd6));
    emit(enc(4'hA, 3'd7, 3'd5, 3'd0));
    emit(enc(4'hC, 3'd4, 3'd0, 3'd0)); emit(16'h0042);
    emit(enc(4'hB, 3'd0, 3'd4, 3'd7));
    expect_wr(8'h40, 16'hBEEF);
    expect_wr(8'h42, 16'hBEEF);
    reset = 1'b0;
    run_to_halt("ldst_halt");
    check("ldst_flags", {C, N, Z}, 3'b100);

    // BZ fall-through, JMP to 0xFF, fetch wrap, BZ taken, HALT sticky.
    begin_prog();
    emit(enc(4'hE, 3'd0, 3'd6, 3'd0));
    emit(enc(4'hC, 3'd6, 3'd0, 3'd0)); emit(16'h0030);
    emit(enc(4'hC, 3'd2, 3'd0, 3'd0)); emit(16'h0077);
    emit(enc(4'hB, 3'd0, 3'd2, 3'd2));
    emit(enc(4'hC, 3'd3, 3'd0, 3'd0)); emit(16'h00FF);
    emit(enc(4'hD, 3'd0, 3'd3, 3'd0));
    mem[8'hFF] = enc(4'h2, 3'd0, 3'd0, 3'd0);
    ld_ptr = 8'h30;
    emit(enc(4'hC, 3'd4, 3'd0, 3'd0)); emit(16'hAAAA);
    emit(enc(4'hB, 3'd0, 3'd6, 3'd4));
    expect_wr(8'h77, 16'h0077);
    expect_wr(8'h30, 16'hAAAA);
    reset = 1'b0;
    run_to_halt("jmp_halt");
    check("jmp_flags", {C, N, Z}, 3'b001);
    check("jmp_pc", pc_dbg, 8'h34);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_quiet", {mem_re, mem_we, halted}, 3'b001);
    end

    // LDI operand at 0xFF wraps PC to 0; W==R==S add reads before writing.
    begin_prog();
    emit(enc(4'hE, 3'd0, 3'd6, 3'd0));
    emit(enc(4'hC, 3'd6, 3'd0, 3'd0)); emit(16'h0030);
    emit(enc(4'hC, 3'd2, 3'd0, 3'd0)); emit(16'h0003);
    emit(enc(4'h1, 3'd2, 3'd2, 3'd2));
    emit(enc(4'hC, 3'd3, 3'd0, 3'd0)); emit(16'h00FE);
    emit(enc(4'h2, 3'd0, 3'd0, 3'd0));
    emit(enc(4'hD, 3'd0, 3'd3, 3'd0));
    mem[8'hFE] = enc(4'hC, 3'd4, 3'd0, 3'd0);
    mem[8'hFF] = 16'h1234;
    ld_ptr = 8'h30;
    emit(enc(4'hB, 3'd0, 3'd6, 3'd4));
    emit(enc(4'hC, 3'd1, 3'd0, 3'd0)); emit(16'h0031);
    emit(enc(4'hB, 3'd0, 3'd1, 3'd2));
    expect_wr(8'h30, 16'h1234);
    expect_wr(8'h31, 16'h0006);
    reset = 1'b0;
    run_to_halt("ldiwrap_halt");
    check("ldiwrap_pc", pc_dbg, 8'h35);

    // Reset while the write strobe is up.
    begin_prog();
    emit(enc(4'hC, 3'd1, 3'd0, 3'd0)); emit(16'h0050);
    emit(enc(4'hB, 3'd0, 3'd1, 3'd1));
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = mem_we;
    end
    check("abort_wr_seen", seen, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_wr_clr", {mem_re, mem_we, halted, C, N, Z}, 6'b0);
    check("abort_wr_bus", {mem_addr, mem_wdata, pc_dbg}, 32'h0);
    prev_pend = 1'b0;
    prev_we   = 1'b0;
    @(negedge clk);
    expect_wr(8'h50, 16'h0050);
    reset = 1'b0;
    step();
    check("abort_wr_restart", {mem_re, mem_addr}, {1'b1, 8'h00});
    run_to_halt("abort_wr_halt");

    // Reset while a load is waiting for read data.
    begin_prog();
    waits = 3;
    emit(enc(4'hC, 3'd1, 3'd0, 3'd0)); emit(16'h0080);
    emit(enc(4'hA, 3'd2, 3'd1, 3'd0));
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = mem_re && (mem_addr == 8'h80);
    end
    check("abort_rd_seen", seen, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_rd_clr", {mem_re, mem_we, mem_addr, pc_dbg}, 18'h0);
    prev_pend = 1'b0;
    prev_we   = 1'b0;
    waits     = 0;
    @(negedge clk);
    reset = 1'b0;
    step();
    check("abort_rd_restart", {mem_re, mem_addr}, {1'b1, 8'h00});
    run_to_halt("abort_rd_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_eu_seq.md
Name: cpu_eu_seq

Overview:
- Parametrised, self-sequencing successor to the CPU execution unit.
- Integrates PC, IR, register file, ALU and flags, plus a fetch/decode/execute FSM that drives an external memory through a read-valid handshake.
- Sits between the top-level memory (RAM/bus) and the debug/display logic.
- Replaces the external control signals (adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld) with internal sequencing.

Parameters:
- DW, 16, data/instruction width; must be ≥ 4+3*RW and ≥ AW.
- AW, 8, memory address width; PC is AW bits and wraps modulo 2^AW.
- NREG, 8, number of general registers; power of two, ≥ 2.
- RW, $clog2(NREG), register-address field width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_rdata  in  DW  read data from memory.
- mem_rvalid  in  1  mem_rdata valid; ignored unless mem_re=1 in the same cycle.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  store data.
- mem_re  out  1  read request; held until mem_rvalid.
- mem_we  out  1  one-cycle write strobe.
- halted  out  1  high while in HALT.
- C, N, Z  out  1 each  ALU flags.
- pc_dbg  out  AW  current PC.

Behaviour:
- Reset (async, active-high):
  - Cleared: PC, IR, all registers, C/N/Z, mem_addr, mem_wdata, mem_re, mem_we, halted.
  - State = FETCH; the first fetch request is issued in the first cycle after reset deasserts.
  - Reset mid-transaction aborts it. No write may occur after reset asserts.
- Instruction fields:
  - op = IR[DW-1:DW-4]
  - W = IR[3*RW-1:2*RW]
  - R = IR[2*RW-1:RW]
  - S = IR[RW-1:0]
  - Remaining bits ignored.
- Opcodes:
  - 0 NOP
  - 1 ADD W=R+S
  - 2 SUB W=R-S
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 INC W=R+1
  - 7 DEC W=R-1
  - 8 SHL W=R<<1
  - 9 SHR W=R>>1 (logical)
  - A LD W=mem[R]
  - B ST mem[R]=S
  - C LDI W=mem[PC], then PC+1
  - D JMP PC=R
  - E BZ: if Z then PC=R
  - F HALT
- Flags:
  - Updated only by ops 1-9.
  - N = result[DW-1]; Z = (result==0).
  - C rules:
    - ADD/INC: C = carry out.
    - SUB/DEC: C = borrow (R<S, or R==0 for DEC).
    - SHL: C = R[DW-1]; SHR: C = R[0].
    - Logic ops: C = 0.
  - Flags hold across LD/ST/LDI/JMP/BZ.
- Address rule: memory addresses from registers use the low AW bits.
- FSM states: FETCH, DECODE, EXEC, MEMRD, MEMWR, HALT.
  - FETCH:
    - mem_addr=PC, mem_re=1.
    - On mem_rvalid: IR<=mem_rdata, PC<=PC+1, go to DECODE.
    - Zero-wait memory (rvalid in the same cycle as re) is legal.
  - DECODE:
    - ops 0-9, D, E → EXEC.
    - A, C → MEMRD.
    - B → MEMWR.
    - F → HALT.
  - EXEC:
    - ALU writeback and flag update, or PC update; → FETCH.
  - MEMRD:
    - mem_re=1; mem_addr = R (LD) or PC (LDI).
    - On mem_rvalid: W<=mem_rdata; for LDI, PC<=PC+1; → FETCH.
  - MEMWR:
    - mem_we=1 for exactly one cycle with mem_addr=R and mem_wdata=S; → FETCH.
  - HALT:
    - Sticky; halted=1, mem_re=mem_we=0; left only by reset.
- Latency with zero-wait memory:
  - ALU/JMP/BZ/NOP: 3 cycles per instruction.
  - LD/LDI/ST: 4 cycles.
  - Each wait cycle extends FETCH/MEMRD by 1.
- Boundary conditions:
  - PC wraps 2^AW-1 → 0, both on fetch and on LDI.
  - W==R==S is legal; the read happens before the write.
  - mem_rvalid outside a read state is ignored.
  - mem_re and mem_we are never high together.
- All outputs are registered or decoded from state only; no combinational path from mem_rvalid to any output.

Decomposition:
- Package cpu_eu_pkg:
  - opcode localparams OP_NOP…OP_HALT.
  - FSM state encoding.
  - Flag bit positions.
- Sub-module cpu_eu_alu (combinational, DW-parametrised): inputs op, R, S; outputs result, C, N, Z.
- Register file, PC, IR and FSM live in cpu_eu_seq.

Test Plan:
- Reset/fetch: release reset, zero-wait memory holding mem[0]=ADD → mem_addr=0 and mem_re=1 in cycle 1; IR loaded; pc_dbg=1 after the fetch.
- ALU/flags: LDI r1,0xFFFF; LDI r2,0x0001; ADD r3,r1,r2 → r3=0x0000, C=1, Z=1, N=0. Then SUB r4,r2,r1 → r4=0x0002, C=1 (borrow).
- Wait states: mem_rvalid delayed 3 cycles on every read → mem_re and mem_addr held stable throughout; instruction count and results identical to the zero-wait run.
- Load/store: r5=0x0040, r6=0xBEEF; ST [r5],r6 → single mem_we pulse, addr 0x40, wdata 0xBEEF. LD r7,[r5] → r7=0xBEEF; flags unchanged.
- Control flow: BZ with Z=0 → falls through. JMP to 0xFF, then a fetch at 0xFF → PC wraps to 0x00. HALT → halted=1, no further mem_re.
- Async reset asserted during MEMWR and during a MEMRD wait → outputs clear immediately; no mem_we pulse; restart fetches from address 0.
